// File: rtl/pulse_meter_if.sv
// pulse_meter_if: pulse input, ack and report outputs of one pulse_meter
interface pulse_meter_if #(
  parameter int W = 8
);
  logic         i_pulse_in;
  logic         i_ack;
  logic         o_meas_valid;
  logic [W-1:0] o_width;
  logic         o_too_short;
  logic         o_overflow;
  logic         o_missed;
  logic         o_busy;
  modport master (
    output i_pulse_in, i_ack,
    input  o_meas_valid, o_width, o_too_short, o_overflow, o_missed, o_busy
  );
  modport slave (
    input  i_pulse_in, i_ack,
    output o_meas_valid, o_width, o_too_short, o_overflow, o_missed, o_busy
  );
endinterface

// File: rtl/pulse_meter.sv
// pulse_meter: measures pulse high-time in clk cycles; PULSE_METER_SYNC_EN adds a two-flop input synchronizer
module pulse_meter #(
  parameter int W       = 8,
  parameter int MIN_LEN = 2
) (
  input  logic          clk,
  input  logic          rst,
  pulse_meter_if.slave  bus
);
  localparam logic [1:0]   ST_IDLE    = 2'd0;
  localparam logic [1:0]   ST_MEASURE = 2'd1;
  localparam logic [1:0]   ST_HOLD    = 2'd2;
  localparam logic [W-1:0] MAX        = '1;
  localparam logic [31:0]  MIN_U      = MIN_LEN;
  localparam logic         SAT1       = (W == 1);
  logic [1:0]   r_state;
  logic [W-1:0] r_count;
  logic [W-1:0] r_width;
  logic         r_ovf_int;
  logic         r_s_d;
  logic         r_blk;
  logic         r_mv;
  logic         r_short;
  logic         r_ovf;
  logic         r_missed;
  logic         w_s;
  logic         w_s_ok;
  logic         w_rise;
  logic [W-1:0] w_count_inc;
`ifdef PULSE_METER_SYNC_EN
  logic       r_sync1;
  logic       r_sync2;
  logic [1:0] r_vld;
  // two-flop synchronizer; r_vld marks when the chain holds real pin samples again after reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_vld   <= 2'b00;
    end else begin
      r_sync1 <= bus.i_pulse_in;
      r_sync2 <= r_sync1;
      r_vld   <= {r_vld[0], 1'b1};
    end
  end
  assign w_s    = r_sync2;
  assign w_s_ok = r_vld[1];
`else
  assign w_s    = bus.i_pulse_in;
  assign w_s_ok = 1'b1;
`endif
  assign w_rise      = w_s & ~r_s_d & ~r_blk;
  assign w_count_inc = (r_count == MAX) ? r_count : r_count + 1'b1;
  // edge history; r_blk keeps a pulse already high at reset release from being measured
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_s_d <= 1'b0;
      r_blk <= 1'b1;
    end else begin
      r_s_d <= w_s;
      if (w_s_ok && !w_s) r_blk <= 1'b0;
    end
  end
  // measurement FSM and held report registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_count   <= '0;
      r_ovf_int <= 1'b0;
      r_mv      <= 1'b0;
      r_width   <= '0;
      r_short   <= 1'b0;
      r_ovf     <= 1'b0;
      r_missed  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_rise) begin
            r_state   <= ST_MEASURE;
            r_count   <= W'(1);
            r_ovf_int <= SAT1;
          end
        end
        ST_MEASURE: begin
          if (w_s) begin
            r_count <= w_count_inc;
            if (w_count_inc == MAX) r_ovf_int <= 1'b1;
          end else begin
            r_state <= ST_HOLD;
            r_width <= r_count;
            r_short <= 32'(r_count) < MIN_U;
            r_ovf   <= r_ovf_int;
            r_mv    <= 1'b1;
          end
        end
        ST_HOLD: begin
          r_missed <= bus.i_ack ? (r_missed & w_rise) : (r_missed | w_rise);
          if (bus.i_ack) begin
            r_mv      <= 1'b0;
            r_state   <= w_rise ? ST_MEASURE : ST_IDLE;
            r_count   <= w_rise ? W'(1) : '0;
            r_ovf_int <= w_rise & SAT1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
  assign bus.o_meas_valid = r_mv;
  assign bus.o_width      = r_width;
  assign bus.o_too_short  = r_short;
  assign bus.o_overflow   = r_ovf;
  assign bus.o_missed     = r_missed;
  assign bus.o_busy       = r_state != ST_IDLE;
endmodule
